// File: rtl/dsp48a1_pkg.sv
// Shared constants and operand-select encodings for the DSP48A1 post-adder stage.
package dsp48a1_pkg;

    localparam int M_W = 36;
    localparam int P_W = 48;

    localparam int OP_CIN = 5;
    localparam int OP_SUB = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } xsel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } zsel_e;

    // Z +/- (X + cin) at P_W+1 bits; the top bit is carry (add) or borrow (sub).
    function automatic logic [P_W:0] addsub(input logic [P_W-1:0] z,
                                            input logic [P_W-1:0] x,
                                            input logic           cin,
                                            input logic           sub);
        logic [P_W:0] zx;
        logic [P_W:0] xc;
        zx = {1'b0, z};
        xc = {1'b0, x} + {{P_W{1'b0}}, cin};
        return sub ? (zx - xc) : (zx + xc);
    endfunction

endpackage

// File: rtl/reg_mux_sync.sv
// Optional pipeline register: REG=1 gives a synchronous-reset, clock-enabled
// register; REG=0 passes d_i straight through.
module reg_mux_sync #(
    parameter int W   = 1,
    parameter int REG = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ce_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            q_q <= '0;
        else if (ce_i)
            q_q <= d_i;
    end

    assign q_o = (REG != 0) ? q_q : d_i;

endmodule

// File: rtl/post_adder_acc.sv
// DSP48A1 post-adder/accumulator: X/Z operand select, add/sub with carry-in,
// optional OPMODE, carry-in and P/CARRYOUT registers.
module post_adder_acc
    import dsp48a1_pkg::*;
#(
    parameter int OPMODEREG  = 1,
    parameter int CARRYINREG = 1,
    parameter int PREG       = 1,
    parameter     CARRYINSEL = "OPMODE5"
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [M_W-1:0] m,
    input  logic [P_W-1:0] dab,
    input  logic [P_W-1:0] c,
    input  logic [P_W-1:0] pcin,
    input  logic [7:0]     opmode,
    input  logic           carryin,
    input  logic           ce_opmode,
    input  logic           ce_carryin,
    input  logic           ce_p,
    output logic [P_W-1:0] p,
    output logic [P_W-1:0] pcout,
    output logic           carryout,
    output logic           carryoutf
);

    localparam logic [1:0] CSEL = (CARRYINSEL == "OPMODE5") ? 2'd0 :
                                  (CARRYINSEL == "CARRYIN") ? 2'd1 : 2'd2;

    logic [7:0]     opm_r;
    logic           cin_d;
    logic           cin_r;
    xsel_e          xsel;
    zsel_e          zsel;
    logic [P_W-1:0] p_fb;
    logic [P_W-1:0] x_opnd;
    logic [P_W-1:0] z_opnd;
    logic [P_W:0]   sum;
    logic [P_W-1:0] p_r;
    logic           co_r;

    reg_mux_sync #(.W(8), .REG(OPMODEREG)) u_opmode (
        .clk_i(clk), .rst_i(reset), .ce_i(ce_opmode), .d_i(opmode), .q_o(opm_r)
    );

    // Carry-in source comes from the raw OPMODE bit; only its own register delays it.
    always_comb begin
        cin_d = 1'b0;
        case (CSEL)
            2'd0:    cin_d = opmode[OP_CIN];
            2'd1:    cin_d = carryin;
            default: cin_d = 1'b0;
        endcase
    end

    reg_mux_sync #(.W(1), .REG(CARRYINREG)) u_carryin (
        .clk_i(clk), .rst_i(reset), .ce_i(ce_carryin), .d_i(cin_d), .q_o(cin_r)
    );

    assign xsel = xsel_e'(opm_r[1:0]);
    assign zsel = zsel_e'(opm_r[3:2]);

    // Without the P register the feedback path is tied off so no loop exists.
    generate
        if (PREG != 0) begin : g_pfb
            assign p_fb = p_r;
        end else begin : g_nofb
            assign p_fb = '0;
        end
    endgenerate

    always_comb begin
        x_opnd = '0;
        case (xsel)
            X_ZERO:  x_opnd = '0;
            X_M:     x_opnd = {{(P_W-M_W){1'b0}}, m};
            X_P:     x_opnd = p_fb;
            X_DAB:   x_opnd = dab;
            default: x_opnd = '0;
        endcase
    end

    always_comb begin
        z_opnd = '0;
        case (zsel)
            Z_ZERO:  z_opnd = '0;
            Z_PCIN:  z_opnd = pcin;
            Z_P:     z_opnd = p_fb;
            Z_C:     z_opnd = c;
            default: z_opnd = '0;
        endcase
    end

    assign sum = addsub(z_opnd, x_opnd, cin_r, opm_r[OP_SUB]);

    reg_mux_sync #(.W(P_W), .REG(PREG)) u_p (
        .clk_i(clk), .rst_i(reset), .ce_i(ce_p), .d_i(sum[P_W-1:0]), .q_o(p_r)
    );

    reg_mux_sync #(.W(1), .REG(PREG)) u_carryout (
        .clk_i(clk), .rst_i(reset), .ce_i(ce_p), .d_i(sum[P_W]), .q_o(co_r)
    );

    assign p         = p_r;
    assign pcout     = p_r;
    assign carryout  = co_r;
    assign carryoutf = co_r;

    logic unused_opm;
    assign unused_opm = ^opm_r[6:4];

endmodule

// File: tb/tb_post_adder_acc.sv
// Scoreboard bench: a fully registered slice (OPMODE5 carry-in) and a fully
// combinational slice (CARRYIN carry-in) share one directed input stream.
module tb_post_adder_acc;

    logic        clk;
    logic        reset;
    logic [35:0] m;
    logic [47:0] dab, c, pcin;
    logic [7:0]  opmode;
    logic        carryin, ce_opmode, ce_carryin, ce_p;

    logic [47:0] p1, pcout1, p2, pcout2;
    logic        co1, cof1, co2, cof2;

    typedef struct {
        int          row;
        logic [47:0] p;
        logic        co;
        logic [47:0] p2;
        logic        co2;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   row_no = 0;

    post_adder_acc #(.OPMODEREG(1), .CARRYINREG(1), .PREG(1), .CARRYINSEL("OPMODE5")) dut_reg (
        .clk(clk), .reset(reset), .m(m), .dab(dab), .c(c), .pcin(pcin),
        .opmode(opmode), .carryin(carryin), .ce_opmode(ce_opmode),
        .ce_carryin(ce_carryin), .ce_p(ce_p),
        .p(p1), .pcout(pcout1), .carryout(co1), .carryoutf(cof1)
    );

    post_adder_acc #(.OPMODEREG(0), .CARRYINREG(0), .PREG(0), .CARRYINSEL("CARRYIN")) dut_comb (
        .clk(clk), .reset(reset), .m(m), .dab(dab), .c(c), .pcin(pcin),
        .opmode(opmode), .carryin(carryin), .ce_opmode(ce_opmode),
        .ce_carryin(ce_carryin), .ce_p(ce_p),
        .p(p2), .pcout(pcout2), .carryout(co2), .carryoutf(cof2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int row, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h, want %h", name, row, act, exp);
        end
    endtask

    // Drive one row at the falling edge; expected values are what the
    // registered slice shows after the next rising edge and what the
    // combinational slice shows while these inputs are held.
    task automatic vec(input logic rst, input logic [7:0] op, input logic [35:0] mm,
                       input logic [47:0] cc, input logic [47:0] dd, input logic [47:0] pc,
                       input logic ci, input logic cep,
                       input logic [47:0] ep, input logic eco,
                       input logic [47:0] ep2, input logic eco2);
        exp_t e;
        @(negedge clk);
        reset = rst; opmode = op; m = mm; c = cc; dab = dd; pcin = pc;
        carryin = ci; ce_p = cep;
        e.row = row_no; e.p = ep; e.co = eco; e.p2 = ep2; e.co2 = eco2;
        sb.push_back(e);
        row_no++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("p_reg",      e.row, p1,             e.p);
                chk("pcout_reg",  e.row, pcout1,         e.p);
                chk("co_reg",     e.row, {47'd0, co1},   {47'd0, e.co});
                chk("cof_reg",    e.row, {47'd0, cof1},  {47'd0, e.co});
                chk("p_comb",     e.row, p2,             e.p2);
                chk("pcout_comb", e.row, pcout2,         e.p2);
                chk("co_comb",    e.row, {47'd0, co2},   {47'd0, e.co2});
                chk("cof_comb",   e.row, {47'd0, cof2},  {47'd0, e.co2});
            end
        end
    end

    localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

    initial begin : stim
        reset = 1'b1; opmode = 8'h00; m = '0; c = '0; dab = '0; pcin = '0;
        carryin = 1'b0; ce_opmode = 1'b1; ce_carryin = 1'b1; ce_p = 1'b1;

        //   rst  op     m    c       dab   pcin   ci cep  exp_p            co  exp_p2           co2
        vec(1, 8'h09, 5,  0,      0,    0,     0, 1, 48'd0,           0,  48'd5,           0); // R0 reset
        vec(0, 8'h09, 5,  0,      0,    0,     0, 1, 48'd0,           0,  48'd5,           0); // R1 opmode reg fill
        vec(0, 8'h09, 5,  0,      0,    0,     0, 1, 48'd5,           0,  48'd5,           0); // R2
        vec(0, 8'h09, 5,  0,      0,    0,     0, 1, 48'd10,          0,  48'd5,           0); // R3
        vec(0, 8'h09, 7,  0,      0,    0,     0, 0, 48'd10,          0,  48'd7,           0); // R4 ce_p low
        vec(0, 8'h09, 7,  0,      0,    0,     0, 0, 48'd10,          0,  48'd7,           0); // R5
        vec(0, 8'h09, 7,  0,      0,    0,     0, 0, 48'd10,          0,  48'd7,           0); // R6
        vec(0, 8'h09, 5,  0,      0,    0,     0, 1, 48'd15,          0,  48'd5,           0); // R7 resume
        vec(1, 8'h09, 5,  0,      0,    0,     0, 1, 48'd0,           0,  48'd5,           0); // R8 mid-run reset
        vec(0, 8'h09, 5,  0,      0,    0,     0, 1, 48'd0,           0,  48'd5,           0); // R9 opmode reg cleared
        vec(0, 8'h09, 5,  0,      0,    0,     0, 1, 48'd5,           0,  48'd5,           0); // R10 restart
        vec(0, 8'h09, 5,  0,      0,    0,     0, 1, 48'd10,          0,  48'd5,           0); // R11
        vec(0, 8'h8D, 5,  3,      0,    0,     0, 1, 48'd15,          0,  48'hFFFF_FFFF_FFFE, 1); // R12
        vec(0, 8'h8D, 5,  3,      0,    0,     0, 1, 48'hFFFF_FFFF_FFFE, 1, 48'hFFFF_FFFF_FFFE, 1); // R13 borrow
        vec(0, 8'h2F, 5,  0,      ONES, 0,     0, 1, 48'hFFFF_FFFF_FFFB, 1, ONES,            0); // R14
        vec(0, 8'h2F, 5,  0,      ONES, 0,     1, 1, 48'd0,           1,  48'd0,           1); // R15 wrap
        vec(0, 8'h05, 1,  200,    0,    100,   0, 1, 48'd201,         0,  48'd101,         0); // R16
        vec(0, 8'h05, 1,  200,    0,    100,   1, 1, 48'd101,         0,  48'd102,         0); // R17
        vec(0, 8'h05, 1,  200,    0,    100,   0, 1, 48'd101,         0,  48'd101,         0); // R18
        vec(0, 8'h0D, 1,  200,    0,    100,   0, 1, 48'd101,         0,  48'd201,         0); // R19 opmode switch
        vec(0, 8'h0D, 1,  200,    0,    100,   0, 1, 48'd201,         0,  48'd201,         0); // R20 takes effect

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries never compared, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
